var_flip_writer: RTL
====================

# var_flip_writer

Write side of the WalkSAT variable tables. Accepts one broken clause (three 12-bit literal indices) from the clause evaluator and picks one non-zero literal. It reads that variable's current value, then issues a single-cycle write of the inverted value. The write drives the shared `evaluator_write` / `flip_var_address` / `flip_value` bus into both evaluator var_table copies. It also counts flips and raises `done` when the configured flip budget is spent.

## Interface
- `LFSR_SEED`, 16'hACE1, non-zero seed for the candidate-selection LFSR.
- `CNT_W`, 32, flip counter / limit width.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `brk_valid`  in  1  broken clause presented on `index1..3`.
- `brk_ready`  out  1  block can accept a clause (high only in IDLE).
- `index1`, `index2`, `index3`  in  12 each  literal indices; [10:0] variable address; value 12'h000 = empty slot.
- `rd_address`  out  11  var_table read address.
- `rd_q`  in  1  var_table read data, valid one cycle after `rd_address` is sampled.
- `evaluator_write`  out  1  write strobe to both var_table copies.
- `flip_var_address`  out  11  write address.
- `flip_value`  out  1  write data (inverted current value).
- `flip_limit`  in  CNT_W  flip budget; 0 = unlimited.
- `clear`  in  1  synchronous restart: counter 0, `done` 0, FSM to IDLE.
- `flip_count`  out  CNT_W  flips issued since reset/clear.
- `done`  out  1  sticky, budget reached.

## Operation
- Reset values:
  - FSM IDLE, so `brk_ready` = 1.
  - `evaluator_write`, `flip_value`, `done` = 0.
  - `flip_var_address`, `rd_address`, `flip_count` = 0.
  - LFSR = `LFSR_SEED`.
- IDLE: handshake on `brk_valid & brk_ready`. Register `index1..3`, go to SELECT.
- SELECT:
  - Preferred slot: `sel = lfsr[1:0]`, with value 3 mapped to slot 0.
  - If the preferred slot is 12'h000, take the next non-zero slot in cyclic order 1→2→3→1.
  - If all three slots are zero: drop the clause, no write, counter unchanged, return to IDLE.
  - Otherwise latch `addr = idx[10:0]` and go to READ.
  - LFSR advances once per SELECT, and only then.
- READ: drive `rd_address = addr`, go to WAIT.
- WAIT: register `rd_q` as `cur`, go to WRITE.
- WRITE:
  - Drive `evaluator_write = 1`, `flip_var_address = addr`, `flip_value = ~cur` for exactly one cycle.
  - Increment `flip_count`; it saturates at all-ones.
  - If `flip_limit != 0` and the new count equals `flip_limit`: set `done`, go to DONE. Otherwise go to IDLE.
- DONE: `brk_ready` = 0, nothing accepted. Leaves only on `clear` or reset.
- `evaluator_write` is 0 in every state except WRITE. `flip_var_address` / `flip_value` hold their last written values outside WRITE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It never reaches zero.

## Timing
- Accept at edge 0: SELECT cycle 1, READ cycle 2 (`rd_address` valid), WAIT cycle 3 (`rd_q` valid), WRITE cycle 4. `brk_ready` returns high in cycle 5.
- Throughput: one flip per 5 cycles. A dropped all-zero clause costs 2 cycles.
- `brk_valid` may stay high across a busy period. It is sampled only in IDLE, and the clause captured is the one present on that edge.
- `clear` has priority over every state transition.
  - A `clear` asserted in WRITE still lets that cycle's write happen.
  - `flip_count` ends at 0, not 1.
- Reset mid-operation aborts immediately. No partial write is emitted after `rst_n` falls.
- A `flip_limit` change takes effect at the next WRITE comparison. Lowering it below the current count does not set `done` until the count wraps, and it cannot wrap because the count saturates; this is intended, and software uses `clear`.

## Configuration
- `FLIP_NOISE_EN` defined: slot choice uses the LFSR as above.
- Undefined:
  - The LFSR is not instantiated.
  - `sel` comes from a 2-bit round-robin counter: 0,1,2,0…, advancing once per SELECT.
  - The zero-skip rule is unchanged.
  - The design is deterministic for golden-model comparison.

## Structure
- `wsat_pkg` holds:
  - `VAR_AW = 11` and `IDX_W = 12`.
  - The FSM state enum (IDLE, SELECT, READ, WAIT, WRITE, DONE).
  - The LFSR tap constant 16'hB400.
- Sub-module `flip_lfsr`:
  - Ports: `clk`, `rst_n`, `step`, `seed`, `q[15:0]`.
  - Instantiated only under `FLIP_NOISE_EN`.

## Test plan
- Round-robin build, indices {12'h005, 12'h00A, 12'h00F}, `rd_q` = 0 → writes to 5, 10, 15 across three clauses; each has `flip_value` = 1 in cycle 4, and `flip_count` = 3.
- Indices {0, 0, 12'h123}, any `sel` → single write to 11'h123. `rd_q` = 1 gives `flip_value` = 0.
- Indices {0, 0, 0} → `brk_ready` high again after 2 cycles, no `evaluator_write`, count unchanged.
- `flip_limit` = 2, four back-to-back clauses → exactly 2 writes, `done` = 1, `brk_ready` held 0. `clear` → `done` 0, count 0, next clause accepted.
- `rst_n` dropped in WAIT → `evaluator_write` never pulses; all outputs at their reset values; IDLE after release.
- `clear` in WRITE cycle → the write pulse is still seen, and `flip_count` reads 0 the next cycle.

Source files
------------

// File: rtl/wsat_pkg.sv
// Shared constants, FSM state encoding and slot-selection helper for the WalkSAT flip path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wsat_pkg;

    localparam int VAR_AW = 11;               // var_table address width
    localparam int IDX_W  = 12;               // literal index width; 12'h000 marks an empty slot

    localparam logic [15:0] LFSR_TAPS = 16'hB400;   // x^16+x^14+x^13+x^11+1, Galois form

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] slot;
    } pick_t;

    // Starting at the preferred slot, walk 0->1->2->0 and return the first
    // occupied slot. pref is always 0..2 by construction at the call site.
    function automatic pick_t pick_slot(input logic [1:0] pref, input logic [2:0] occupied);
        pick_t      p;
        logic [1:0] s;
        p.found = 1'b0;
        p.slot  = 2'd0;
        s       = pref;
        for (int k = 0; k < 3; k++) begin
            if (!p.found && occupied[s]) begin
                p.found = 1'b1;
                p.slot  = s;
            end
            s = (s == 2'd2) ? 2'd0 : s + 2'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/flip_lfsr.sv
// 16-bit Galois LFSR used to randomise which literal of a broken clause gets flipped.
// Latency: q updates on the rising edge after step is high; reset loads seed.
// Backpressure: none; advances only when step is asserted.
//
// Ports: clk, rst_n (async active-low), step (advance one position),
//        seed (reset value, must be non-zero), q (current state).
module flip_lfsr
    import wsat_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (step) begin
            // A non-zero state never maps to zero under this polynomial.
            q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/var_flip_writer.sv
// Picks one literal of a broken clause, reads its variable, writes back the inverse; counts flips against a budget.
// Latency: accept at edge 0, rd_address valid cycle 2, write strobe cycle 4, ready again cycle 5; all-zero clause drops in 2 cycles.
// Backpressure: brk_ready is high only in IDLE; held low while busy and permanently in DONE until clear/reset.
//
// Ports: clk, rst_n (async active-low); brk_valid/brk_ready + index1..3 clause input;
//        rd_address/rd_q var_table read port (1-cycle read latency);
//        evaluator_write/flip_var_address/flip_value shared write bus to both var_table copies;
//        flip_limit (0 = unlimited), clear (sync restart), flip_count, done (sticky).
// Build option: define FLIP_NOISE_EN to choose the preferred slot from the LFSR;
//        otherwise a 0,1,2 round-robin counter is used and the design is fully deterministic.
module var_flip_writer
    import wsat_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 brk_valid,
    output logic                 brk_ready,
    input  logic [IDX_W-1:0]     index1,
    input  logic [IDX_W-1:0]     index2,
    input  logic [IDX_W-1:0]     index3,
    output logic [VAR_AW-1:0]    rd_address,
    input  logic                 rd_q,
    output logic                 evaluator_write,
    output logic [VAR_AW-1:0]    flip_var_address,
    output logic                 flip_value,
    input  logic [CNT_W-1:0]     flip_limit,
    input  logic                 clear,
    output logic [CNT_W-1:0]     flip_count,
    output logic                 done
);

    if (LFSR_SEED == 16'h0000) begin : g_seed_check
        $error("var_flip_writer: LFSR_SEED must be non-zero");
    end

    state_t                      state;
    logic [2:0][IDX_W-1:0]       idx_q;       // slot 0 = index1
    logic [VAR_AW-1:0]           addr_q;
    logic [1:0]                  pref;
    logic [2:0]                  occupied;
    pick_t                       pick;
    logic [IDX_W-1:0]            chosen_idx;
    logic [CNT_W-1:0]            cnt_next;

    assign brk_ready = (state == ST_IDLE);

`ifdef FLIP_NOISE_EN
    logic [15:0] lfsr_q;

    flip_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (state == ST_SELECT),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Value 3 folds onto slot 0, so slot 0 is preferred twice as often.
    assign pref = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
`else
    logic [1:0] rr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 2'd0;
        end else if (state == ST_SELECT) begin
            rr_q <= (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
        end
    end

    assign pref = rr_q;
`endif

    assign occupied   = {|idx_q[2], |idx_q[1], |idx_q[0]};
    assign pick       = pick_slot(pref, occupied);
    assign chosen_idx = idx_q[pick.slot];

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cnt_next = (&flip_count) ? flip_count : flip_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            idx_q            <= '0;
            addr_q           <= '0;
            rd_address       <= '0;
            evaluator_write  <= 1'b0;
            flip_var_address <= '0;
            flip_value       <= 1'b0;
            flip_count       <= '0;
            done             <= 1'b0;
        end else if (clear) begin
            // A write already on the bus this cycle still completes; only
            // future activity is cancelled.
            state           <= ST_IDLE;
            evaluator_write <= 1'b0;
            flip_count      <= '0;
            done            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (brk_valid) begin
                        idx_q <= {index3, index2, index1};
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (pick.found) begin
                        addr_q     <= chosen_idx[VAR_AW-1:0];
                        rd_address <= chosen_idx[VAR_AW-1:0];
                        state      <= ST_READ;
                    end else begin
                        state <= ST_IDLE;   // empty clause: dropped silently
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // rd_q is valid now; the inverted value goes straight onto
                    // the registered write bus for the WRITE cycle.
                    evaluator_write  <= 1'b1;
                    flip_var_address <= addr_q;
                    flip_value       <= ~rd_q;
                    state            <= ST_WRITE;
                end
                ST_WRITE: begin
                    evaluator_write <= 1'b0;
                    flip_count      <= cnt_next;
                    if ((flip_limit != '0) && (cnt_next == flip_limit)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
